// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared state encoding and register constants for the hazard
//            sequencer of the 5-stage merge-sort core.
// Revision : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_REFILL   = 2'd2;

    localparam logic [4:0] c_X0 = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = c_RUN,
        ST_MEM_WAIT = c_MEM_WAIT,
        ST_REFILL   = c_REFILL
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush sequencer for PC, IF_ID, ID_EX and EX_MEM.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_lw,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] c_REM_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_rem;
    state_t     w_next_state;
    logic [2:0] w_next_rem;
    logic       w_lu;
    logic       w_mem_wait;
    logic       w_freeze;
    logic       w_inc_flush;

    assign w_lu = ex_lw && (ex_rd != c_X0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

    assign w_mem_wait = mem_req && !mem_ready;

    always_comb begin
        w_next_state = r_state;
        w_next_rem   = r_rem;
        w_freeze     = 1'b0;
        w_inc_flush  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        busy         = 1'b0;

        if (reset) begin
            // Clearing both pipe registers keeps garbage out of the core while held in reset.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            busy = (r_state != ST_RUN);
            case (r_state)
                ST_RUN: begin
                    if (w_mem_wait) begin
                        w_freeze     = 1'b1;
                        w_next_state = ST_MEM_WAIT;
                    end else if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        w_inc_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_next_state = ST_REFILL;
                            w_next_rem   = c_REM_LOAD;
                        end
                    end else if (w_lu) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ready) begin
                        w_freeze = 1'b1;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_REFILL: begin
                    if (w_mem_wait) begin
                        w_freeze = 1'b1;
                    end else if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        w_inc_flush = 1'b1;
                        w_next_rem  = c_REM_LOAD;
                    end else begin
                        if_id_flush = 1'b1;
                        w_next_rem  = r_rem - 3'd1;
                        if (r_rem <= 3'd1) begin
                            w_next_state = ST_RUN;
                        end
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_rem   = 3'd0;
                end
            endcase

            if (w_freeze) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
            end
        end
    end

    assign id_ex_stall  = w_freeze;
    assign ex_mem_stall = w_freeze;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc_flush),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed + random scoreboard bench for pipeline_hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int FLUSH_CYCLES = 3;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_lw = 1'b0;
    logic             ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic             pc_stall, if_id_stall, if_id_flush;
    logic             id_ex_stall, id_ex_flush, ex_mem_stall, busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic [6:0]       flags;  // pc_stall,if_id_stall,if_id_flush,id_ex_stall,id_ex_flush,ex_mem_stall,busy
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: "waiting" for memory, and how many more refill flush cycles remain.
    bit   m_waiting = 0;
    int   m_refill_left = 0;
    int   m_scnt = 0;
    int   m_fcnt = 0;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_lw        (ex_lw),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_stall (ex_mem_stall),
        .busy         (busy),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit rst, input bit redir, input bit mreq, input bit mrdy,
                         input bit lw, input int rd, input int rs1, input int rs2,
                         input bit u1, input bit u2);
        bit   all_stall, ifl, ifl_idex, ls, lu, mw;
        exp_t e;
        @(negedge clk);
        reset = rst; ex_redirect = redir; mem_req = mreq; mem_ready = mrdy;
        ex_lw = lw; ex_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2;

        e.scnt = CNT_W'(m_scnt);
        e.fcnt = CNT_W'(m_fcnt);
        all_stall = 0; ifl = 0; ifl_idex = 0; ls = 0;
        lu = lw && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        mw = mreq && !mrdy;
        if (rst) begin
            e.flags = 7'b0010100;
            m_waiting = 0; m_refill_left = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            e.flags[0] = m_waiting || (m_refill_left > 0);
            if (m_waiting) begin
                if (!mrdy) all_stall = 1; else m_waiting = 0;
            end else if (mw) begin
                all_stall = 1;
                if (m_refill_left == 0) m_waiting = 1;
            end else if (redir) begin
                ifl = 1; ifl_idex = 1;
                if (m_fcnt < CNT_MAX) m_fcnt++;
                m_refill_left = FLUSH_CYCLES - 1;
            end else if (m_refill_left > 0) begin
                ifl = 1;
                m_refill_left--;
            end else if (lu) begin
                ls = 1; ifl_idex = 1;
            end
            e.flags[6:1] = {all_stall | ls, all_stall | ls, ifl, all_stall, ifl_idex, all_stall};
            if ((all_stall || ls) && m_scnt < CNT_MAX) m_scnt++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: samples mid-low-phase, well away from the rising edge.
    initial begin
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, busy};
                checks += 3;
                if (act !== e.flags) begin
                    errors++;
                    $display("FAIL flags t=%0t got=%b want=%b", $time, act, e.flags);
                end
                if (stall_cnt !== e.scnt) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.scnt);
                end
                if (flush_cnt !== e.fcnt) begin
                    errors++;
                    $display("FAIL flush_cnt t=%0t got=%0d want=%0d", $time, flush_cnt, e.fcnt);
                end
                if (!reset) begin
                    checks++;
                    if ((pc_stall && 1'b0) || (if_id_stall && if_id_flush) || (id_ex_stall && id_ex_flush)) begin
                        errors++;
                        $display("FAIL stall_flush_overlap t=%0t if_id=%b%b id_ex=%b%b want no overlap",
                                 $time, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush);
                    end
                end
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use on rs2, then the same with x0 as destination.
        drive(0, 0, 0, 0, 1, 5, 0, 5, 0, 1);
        idle(2);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        idle(1);
        // Single redirect pulse.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // Four-cycle memory wait.
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Redirect with coincident load-use.
        drive(0, 1, 0, 0, 1, 3, 3, 0, 1, 0);
        idle(3);
        // Memory wait with a redirect pending in EX.
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Reset in the middle of a refill.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // Saturation of stall_cnt.
        for (int i = 0; i < 20; i++) drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Random traffic with narrow register ranges so hazards are frequent.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 1) == 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0));
        end
        idle(1);
        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
